// File: rtl/projectile_pool.sv
// Fixed pool of projectile slots: lowest-free-slot allocation with a fire cooldown,
// per-frame motion with playfield-bounds retirement, kill-by-index, and a pixel lookup.
`timescale 1ns/1ps
module projectile_pool #(
    parameter int N_SLOTS  = 15,
    parameter int SIZE_X   = 3,
    parameter int SIZE_Y   = 8,
    parameter int COOLDOWN = 4,
    parameter int MAX_X    = 639,
    parameter int MAX_Y    = 479
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               fire,
    input  logic [9:0]         spawn_x,
    input  logic [9:0]         spawn_y,
    input  logic [9:0]         step_x,
    input  logic [9:0]         step_y,
    input  logic               kill_valid,
    input  logic [4:0]         kill_idx,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic [N_SLOTS-1:0] active,
    output logic               fire_ack,
    output logic               fire_drop,
    output logic [5:0]         live_count,
    output logic               pix_hit,
    output logic [4:0]         pix_idx,
    output logic [9:0]         pix_dx,
    output logic [9:0]         pix_dy
);

    localparam int              CD_W      = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CD_W-1:0] CD_RELOAD = CD_W'(COOLDOWN);

    typedef enum logic {
        IDLE = 1'b0,
        FLY  = 1'b1
    } slot_state_e;

    slot_state_e     state_q [N_SLOTS];
    slot_state_e     state_d [N_SLOTS];
    logic [9:0]      x_q     [N_SLOTS];
    logic [9:0]      x_d     [N_SLOTS];
    logic [9:0]      y_q     [N_SLOTS];
    logic [9:0]      y_d     [N_SLOTS];
    logic [9:0]      vx_q    [N_SLOTS];
    logic [9:0]      vx_d    [N_SLOTS];
    logic [9:0]      vy_q    [N_SLOTS];
    logic [9:0]      vy_d    [N_SLOTS];
    logic [CD_W-1:0] cd_q, cd_d;
    logic            ack_q, ack_d;
    logic            drop_q, drop_d;
    logic [5:0]      live_q, live_d;

    logic               any_idle;
    logic [4:0]         alloc_idx;
    logic               accept;
    logic [10:0]        nx [N_SLOTS];
    logic [10:0]        ny [N_SLOTS];
    logic [N_SLOTS-1:0] out_of_bounds;
    logic [N_SLOTS-1:0] kill_hit;

    // Lowest-index free slot, taken from the registered state so that slots
    // retiring on this edge are never handed out in the same cycle.
    always_comb begin
        any_idle  = 1'b0;
        alloc_idx = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (state_q[i] == IDLE) begin
                any_idle  = 1'b1;
                alloc_idx = 5'(i);
            end
        end
    end

    assign accept = fire && (cd_q == '0) && any_idle;

    // Candidate next position in 11 bits; bit 10 set means it went negative.
    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            nx[i] = {1'b0, x_q[i]} + {vx_q[i][9], vx_q[i]};
            ny[i] = {1'b0, y_q[i]} + {vy_q[i][9], vy_q[i]};
            out_of_bounds[i] = nx[i][10] || ny[i][10]
                            || (({1'b0, nx[i]} + 12'(SIZE_X)) > 12'(MAX_X))
                            || (({1'b0, ny[i]} + 12'(SIZE_Y)) > 12'(MAX_Y));
            kill_hit[i] = kill_valid && (kill_idx == 5'(i));
        end
    end

    // NOTE: every always_comb output gets its default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            vx_d[i]    = vx_q[i];
            vy_d[i]    = vy_q[i];

            if (state_q[i] == FLY) begin
                if (kill_hit[i] || out_of_bounds[i]) begin
                    // Position is frozen on the retiring edge.
                    state_d[i] = IDLE;
                end else begin
                    x_d[i] = nx[i][9:0];
                    y_d[i] = ny[i][9:0];
                end
            end else if (accept && (alloc_idx == 5'(i))) begin
                state_d[i] = FLY;
                x_d[i]     = spawn_x;
                y_d[i]     = spawn_y;
                vx_d[i]    = step_x;
                vy_d[i]    = step_y;
            end
        end

        if (accept) begin
            cd_d = CD_RELOAD;
        end else if (cd_q != '0) begin
            cd_d = cd_q - 1'b1;
        end else begin
            cd_d = '0;
        end

        ack_d  = accept;
        drop_d = fire && !accept;

        live_d = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            live_d = live_d + 6'(state_d[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            // NOTE: the slot arrays are cleared explicitly; they are plain flops, not RAM, so reset is cheap and keeps them X-free.
            for (int i = 0; i < N_SLOTS; i++) begin
                state_q[i] <= IDLE;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                vx_q[i]    <= '0;
                vy_q[i]    <= '0;
            end
            cd_q   <= '0;
            ack_q  <= 1'b0;
            drop_q <= 1'b0;
            live_q <= '0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                vx_q[i]    <= vx_d[i];
                vy_q[i]    <= vy_d[i];
            end
            cd_q   <= cd_d;
            ack_q  <= ack_d;
            drop_q <= drop_d;
            live_q <= live_d;
        end
    end

    always_comb begin
        active = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            active[i] = (state_q[i] == FLY);
        end
    end

    assign fire_ack   = ack_q;
    assign fire_drop  = drop_q;
    assign live_count = live_q;

    // Scan high to low so the lowest matching slot is the last writer.
    always_comb begin
        pix_hit = 1'b0;
        pix_idx = '0;
        pix_dx  = '0;
        pix_dy  = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if ((state_q[i] == FLY)
                && (DrawX >= x_q[i]) && ({1'b0, DrawX} <= ({1'b0, x_q[i]} + 11'(SIZE_X)))
                && (DrawY >= y_q[i]) && ({1'b0, DrawY} <= ({1'b0, y_q[i]} + 11'(SIZE_Y)))) begin
                pix_hit = 1'b1;
                pix_idx = 5'(i);
                pix_dx  = DrawX - x_q[i];
                pix_dy  = DrawY - y_q[i];
            end
        end
    end

endmodule

// File: tb/tb_projectile_pool.sv
// Bench for projectile_pool: directed scenarios plus randomized traffic against a
// slot-list reference model; a second small instance covers the tiny-pool cases.
`timescale 1ns/1ps
module tb_projectile_pool;

    localparam int N  = 15;
    localparam int SX = 3;
    localparam int SY = 8;
    localparam int CD = 4;
    localparam int MX = 639;
    localparam int MY = 479;

    logic frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // Default-parameter instance
    logic         reset, fire, kill_valid;
    logic [9:0]   spawn_x, spawn_y, step_x, step_y, draw_x, draw_y;
    logic [4:0]   kill_idx;
    logic [N-1:0] active;
    logic         ack, drop, pix_hit;
    logic [5:0]   live;
    logic [4:0]   pix_idx;
    logic [9:0]   pix_dx, pix_dy;

    projectile_pool u_dut (
        .frame_clk (frame_clk), .Reset (reset), .fire (fire),
        .spawn_x (spawn_x), .spawn_y (spawn_y), .step_x (step_x), .step_y (step_y),
        .kill_valid (kill_valid), .kill_idx (kill_idx), .DrawX (draw_x), .DrawY (draw_y),
        .active (active), .fire_ack (ack), .fire_drop (drop), .live_count (live),
        .pix_hit (pix_hit), .pix_idx (pix_idx), .pix_dx (pix_dx), .pix_dy (pix_dy)
    );

    // Three-slot, no-cooldown instance
    logic         s_reset, s_fire, s_kill_valid;
    logic [4:0]   s_kill_idx;
    logic [2:0]   s_active;
    logic         s_ack, s_drop, s_pix_hit;
    logic [5:0]   s_live;
    logic [4:0]   s_pix_idx;
    logic [9:0]   s_pix_dx, s_pix_dy;

    projectile_pool #(.N_SLOTS(3), .COOLDOWN(0)) u_small (
        .frame_clk (frame_clk), .Reset (s_reset), .fire (s_fire),
        .spawn_x (10'd100), .spawn_y (10'd100), .step_x (10'd0), .step_y (10'd0),
        .kill_valid (s_kill_valid), .kill_idx (s_kill_idx), .DrawX (10'd0), .DrawY (10'd0),
        .active (s_active), .fire_ack (s_ack), .fire_drop (s_drop), .live_count (s_live),
        .pix_hit (s_pix_hit), .pix_idx (s_pix_idx), .pix_dx (s_pix_dx), .pix_dy (s_pix_dy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a list of slots with plain integer coordinates.
    typedef struct {
        bit fly;
        int x, y, vx, vy;
    } slot_t;

    slot_t m[N];
    int    m_cd;
    bit    m_ack, m_drop;

    function automatic int sext10(input logic [9:0] v);
        return v[9] ? int'(v) - 1024 : int'(v);
    endfunction

    function automatic void model_edge();
        int  idx;
        bit  acc;
        int  nx, ny;
        if (reset) begin
            for (int i = 0; i < N; i++) m[i] = '{fly: 1'b0, x: 0, y: 0, vx: 0, vy: 0};
            m_cd = 0; m_ack = 0; m_drop = 0;
            return;
        end
        idx = -1;
        for (int i = 0; i < N; i++) if (!m[i].fly) begin idx = i; break; end
        acc = fire && (m_cd == 0) && (idx >= 0);
        for (int i = 0; i < N; i++) begin
            if (m[i].fly) begin
                nx = m[i].x + m[i].vx;
                ny = m[i].y + m[i].vy;
                if ((kill_valid && int'(kill_idx) == i) || nx < 0 || nx + SX > MX || ny < 0 || ny + SY > MY)
                    m[i].fly = 1'b0;
                else begin
                    m[i].x = nx;
                    m[i].y = ny;
                end
            end
        end
        if (acc) m[idx] = '{fly: 1'b1, x: int'(spawn_x), y: int'(spawn_y), vx: sext10(step_x), vy: sext10(step_y)};
        m_cd   = acc ? CD : (m_cd > 0 ? m_cd - 1 : 0);
        m_ack  = acc;
        m_drop = fire && !acc;
    endfunction

    function automatic logic [N-1:0] m_active();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m[i].fly;
        return v;
    endfunction

    function automatic int m_live();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m[i].fly);
        return c;
    endfunction

    task automatic check_pix(input string tag);
        bit hit = 0;
        int idx = 0, ox = 0, oy = 0;
        int dx = int'(draw_x), dy = int'(draw_y);
        for (int i = 0; i < N; i++) begin
            if (m[i].fly && dx >= m[i].x && dx <= m[i].x + SX && dy >= m[i].y && dy <= m[i].y + SY) begin
                hit = 1; idx = i; ox = dx - m[i].x; oy = dy - m[i].y;
                break;
            end
        end
        check({tag, ".pix_hit"}, pix_hit, hit);
        check({tag, ".pix_idx"}, pix_idx, idx);
        check({tag, ".pix_dx"},  pix_dx,  ox);
        check({tag, ".pix_dy"},  pix_dy,  oy);
    endtask

    task automatic pix_at(input int px, input int py, input string tag);
        draw_x = 10'(px);
        draw_y = 10'(py);
        #1;
        check_pix(tag);
    endtask

    // One frame: edge, model update, register checks, then a pixel probe.
    task automatic tick(input string tag);
        int fl[$];
        @(posedge frame_clk);
        #1;
        model_edge();
        check({tag, ".active"}, active, m_active());
        check({tag, ".live"},   live,   m_live());
        check({tag, ".ack"},    ack,    m_ack);
        check({tag, ".drop"},   drop,   m_drop);
        for (int i = 0; i < N; i++) if (m[i].fly) fl.push_back(i);
        if (fl.size() > 0 && $urandom_range(0, 3) != 0) begin
            int k = fl[$urandom_range(0, fl.size() - 1)];
            draw_x = 10'(m[k].x + int'($urandom_range(0, SX + 1)));
            draw_y = 10'(m[k].y + int'($urandom_range(0, SY + 1)));
        end else begin
            draw_x = 10'($urandom_range(0, MX));
            draw_y = 10'($urandom_range(0, MY));
        end
        #1;
        check_pix(tag);
    endtask

    task automatic launch(input int px, input int py, input int vx, input int vy);
        fire = 1'b1; spawn_x = 10'(px); spawn_y = 10'(py); step_x = 10'(vx); step_y = 10'(vy);
    endtask

    initial begin
        reset = 1; fire = 0; kill_valid = 0; kill_idx = 0;
        spawn_x = 0; spawn_y = 0; step_x = 0; step_y = 0; draw_x = 0; draw_y = 0;
        s_reset = 1; s_fire = 0; s_kill_valid = 0; s_kill_idx = 0;
        for (int i = 0; i < N; i++) m[i] = '{fly: 1'b0, x: 0, y: 0, vx: 0, vy: 0};
        m_cd = 0; m_ack = 0; m_drop = 0;

        tick("rst0");
        tick("rst1");
        check("rst.active", active, 0);
        check("rst.live", live, 0);
        check("rst.ack", ack, 0);
        check("small.rst.active", s_active, 0);
        reset = 0; s_reset = 0;

        // Single flight
        launch(100, 50, 2, 1);
        tick("fly.e1");
        check("fly.e1.active", active, 1);
        check("fly.e1.ack", ack, 1);
        fire = 0;
        for (int e = 0; e < 3; e++) tick("fly.run");
        pix_at(106, 53, "fly.pos");
        check("fly.pos.hit", pix_hit, 1);
        check("fly.pos.dx", pix_dx, 0);
        pix_at(105, 53, "fly.left");
        check("fly.left.hit", pix_hit, 0);
        pix_at(109, 61, "fly.corner");
        check("fly.corner.dy", pix_dy, 8);
        pix_at(110, 61, "fly.outside");
        reset = 1; tick("fly.rst"); reset = 0;

        // Cooldown with fire held high
        launch(300, 200, 0, 0);
        for (int e = 1; e <= 12; e++) begin
            tick("cd");
            check($sformatf("cd.e%0d.ack", e), ack, (e == 1 || e == 6 || e == 11));
            check($sformatf("cd.e%0d.drop", e), drop, !(e == 1 || e == 6 || e == 11));
        end
        fire = 0;
        reset = 1; tick("cd.rst"); reset = 0;

        // Right-edge bounds retire
        launch(630, 10, 3, 0);
        tick("bx.e1");
        fire = 0;
        tick("bx.e2");
        tick("bx.e3");
        check("bx.e3.active", active[0], 1);
        pix_at(636, 10, "bx.held");
        check("bx.held.hit", pix_hit, 1);
        tick("bx.e4");
        check("bx.e4.active", active[0], 0);
        reset = 1; tick("bx.rst"); reset = 0;

        // Left-edge bounds retire
        launch(2, 100, -3, 0);
        tick("bl.e1");
        fire = 0;
        tick("bl.e2");
        check("bl.e2.active", active[0], 0);
        reset = 1; tick("bl.rst"); reset = 0;

        // Pixel priority between overlapping slots 0 and 2
        launch(198, 96, 0, 0);
        tick("pp.s0");
        fire = 0;
        for (int e = 0; e < 4; e++) tick("pp.wait");
        launch(400, 400, 0, 0);
        tick("pp.s1");
        fire = 0;
        for (int e = 0; e < 4; e++) tick("pp.wait");
        launch(199, 95, 0, 0);
        tick("pp.s2");
        fire = 0;
        check("pp.active", active, 15'h7);
        pix_at(200, 100, "pp.ovl");
        check("pp.ovl.idx", pix_idx, 0);
        check("pp.ovl.dx", pix_dx, 2);
        check("pp.ovl.dy", pix_dy, 4);
        kill_valid = 1; kill_idx = 0;
        tick("pp.kill0");
        kill_valid = 0;
        pix_at(200, 100, "pp.ovl2");
        check("pp.ovl2.idx", pix_idx, 2);
        check("pp.ovl2.dy", pix_dy, 5);

        // Kill and accepted fire on different slots in one cycle
        for (int e = 0; e < 4; e++) tick("kf.wait");
        kill_valid = 1; kill_idx = 2;
        launch(50, 50, 0, 0);
        tick("kf");
        check("kf.active", active, 15'h3);
        check("kf.ack", ack, 1);
        fire = 0;
        kill_idx = 5;
        tick("kf.idle_kill");
        check("kf.idle_kill.active", active, 15'h3);
        kill_idx = 20;
        tick("kf.range_kill");
        check("kf.range_kill.active", active, 15'h3);
        kill_valid = 0;

        // Reset mid-flight overrides a pending fire; fire lands right after
        reset = 1; fire = 1;
        tick("mr.rst");
        check("mr.rst.ack", ack, 0);
        check("mr.rst.live", live, 0);
        reset = 0;
        tick("mr.fire");
        check("mr.fire.ack", ack, 1);
        check("mr.fire.active", active, 15'h1);
        fire = 0;

        // Small pool: fill, overflow, kill plus fire, refill
        s_fire = 1;
        for (int e = 1; e <= 4; e++) begin
            tick("sm.fill");
            check($sformatf("sm.e%0d.active", e), s_active, (e >= 3) ? 3'b111 : ((e == 2) ? 3'b011 : 3'b001));
            check($sformatf("sm.e%0d.ack", e), s_ack, e <= 3);
            check($sformatf("sm.e%0d.drop", e), s_drop, e == 4);
        end
        check("sm.live", s_live, 3);
        s_kill_valid = 1; s_kill_idx = 1;
        tick("sm.killfire");
        check("sm.killfire.active", s_active, 3'b101);
        check("sm.killfire.drop", s_drop, 1);
        check("sm.killfire.live", s_live, 2);
        s_kill_valid = 0;
        tick("sm.refill");
        check("sm.refill.active", s_active, 3'b111);
        check("sm.refill.ack", s_ack, 1);
        s_fire = 0;
        s_kill_valid = 1; s_kill_idx = 3;
        tick("sm.range_kill");
        check("sm.range_kill.active", s_active, 3'b111);
        s_kill_valid = 0;

        // Randomized traffic
        reset = 1; tick("rnd.rst"); reset = 0;
        for (int c = 0; c < 400; c++) begin
            reset      = ($urandom_range(0, 99) == 0);
            fire       = ($urandom_range(0, 9) < 4);
            spawn_x    = 10'($urandom_range(0, MX - SX));
            spawn_y    = 10'($urandom_range(0, MY - SY));
            step_x     = 10'(int'($urandom_range(0, 16)) - 8);
            step_y     = 10'(int'($urandom_range(0, 16)) - 8);
            kill_valid = ($urandom_range(0, 4) == 0);
            kill_idx   = 5'($urandom_range(0, 17));
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
